// File: rtl/dlatch_input_conditioner.sv
// Conditions the raw data/enable pads for the D-latch block: it synchronizes and
// debounces both pads, then drives the latch EN as a level or a fixed-width strobe.
module dlatch_cond_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   w_sync;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // Any matching cycle restarts the count, so glitches never accumulate.
      if (w_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= w_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module dlatch_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EN_PULSE_CYCLES = 1,
  parameter int EN_MODE         = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ena,
  input  logic       i_raw_d,
  input  logic       i_raw_en,
  output logic       o_d_out,
  output logic       o_en_out,
  output logic       o_busy,
  output logic [7:0] o_strobe_cnt
);
  localparam int NUM_CH = 2;
  localparam int CH_D   = 0;
  localparam int CH_EN  = 1;
  localparam int PW     = $clog2(EN_PULSE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_LOW} state_t;

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_stable;
  state_t            r_state, w_nxt;
  logic [PW-1:0]     r_pcnt;
  logic              r_en_prev, r_d_hold, r_d_out, r_en_out, r_busy;
  logic [7:0]        r_strobe_cnt;
  logic              w_rise, w_load;

  assign w_raw = {i_raw_en, i_raw_d};

  for (genvar g_ch = 0; g_ch < NUM_CH; g_ch++) begin : g_chan
    dlatch_cond_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (w_raw[g_ch]),
      .o_stable(w_stable[g_ch])
    );
  end

  // The previous level is tracked even while disabled, so a level that is already
  // high when ena returns does not count as a fresh press.
  assign w_rise = w_stable[CH_EN] & ~r_en_prev;

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    if (EN_MODE != 0) begin
      case (r_state)
        S_IDLE:     if (i_ena && w_rise) begin
                      w_nxt  = S_PULSE;
                      w_load = 1'b1;
                    end
        S_PULSE:    if (r_pcnt == '0) w_nxt = S_WAIT_LOW;
        S_WAIT_LOW: if (!w_stable[CH_EN]) w_nxt = S_IDLE;
        default:    w_nxt = S_IDLE;
      endcase
      if (!i_ena) w_nxt = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pcnt       <= '0;
      r_en_prev    <= 1'b0;
      r_d_hold     <= 1'b0;
      r_d_out      <= 1'b0;
      r_en_out     <= 1'b0;
      r_busy       <= 1'b0;
      r_strobe_cnt <= '0;
    end else begin
      r_state   <= w_nxt;
      r_busy    <= (w_nxt != S_IDLE);
      r_en_prev <= w_stable[CH_EN];
      if (w_load) begin
        r_d_hold     <= w_stable[CH_D];
        r_pcnt       <= PW'(EN_PULSE_CYCLES - 1);
        r_strobe_cnt <= r_strobe_cnt + 1'b1;
      end else if (r_state == S_PULSE && r_pcnt != '0) begin
        r_pcnt <= r_pcnt - 1'b1;
      end
      if (EN_MODE == 0) begin
        r_d_out  <= w_stable[CH_D];
        r_en_out <= w_stable[CH_EN] & i_ena;
      end else begin
        // Outputs are decoded from the next state so they change with the state.
        r_en_out <= (w_nxt == S_PULSE);
        r_d_out  <= (w_nxt == S_IDLE || w_load) ? w_stable[CH_D] : r_d_hold;
      end
    end
  end

  assign o_d_out      = r_d_out;
  assign o_en_out     = r_en_out;
  assign o_busy       = r_busy;
  assign o_strobe_cnt = r_strobe_cnt;
endmodule

// File: tb/tb_dlatch_input_conditioner.sv
// Directed bench: a pulse-mode instance (S=2, D=4, P=3) and a level-mode instance
// share the same pad stimulus; expected values are hand-derived edge counts.
module tb_dlatch_input_conditioner;
  logic       clk = 1'b0;
  logic       rst_n, ena, raw_d, raw_en;
  logic       p_d, p_en, p_busy, l_d, l_en, l_busy;
  logic [7:0] p_cnt, l_cnt;
  int         n_tests = 0, n_fail = 0;
  int         hi;

  always #5 clk = ~clk;

  dlatch_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                             .EN_PULSE_CYCLES(3), .EN_MODE(1)) u_pls (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_raw_d(raw_d), .i_raw_en(raw_en),
    .o_d_out(p_d), .o_en_out(p_en), .o_busy(p_busy), .o_strobe_cnt(p_cnt));

  dlatch_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                             .EN_PULSE_CYCLES(1), .EN_MODE(0)) u_lvl (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_raw_d(raw_d), .i_raw_en(raw_en),
    .o_d_out(l_d), .o_en_out(l_en), .o_busy(l_busy), .o_strobe_cnt(l_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit past it; inputs change here.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int n_hold);
    raw_en = 1'b1;
    step(n_hold);
    raw_en = 1'b0;
    step(8);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; raw_d = 1'b0; raw_en = 1'b0;
    // Reset holds everything low while the pads toggle.
    for (int i = 0; i < 6; i++) begin
      raw_d = i[0]; raw_en = ~i[0];
      step(1);
    end
    chk("rst_d", p_d, 0);
    chk("rst_en", p_en, 0);
    chk("rst_busy", p_busy, 0);
    chk("rst_cnt", p_cnt, 0);
    chk("rst_lvl_en", l_en, 0);
    raw_d = 1'b1; raw_en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(12);

    // Latency + held button with a 1-cycle low glitch at cycle 30.
    raw_en = 1'b1;
    hi = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      if (k <= 12) chk($sformatf("lat_en_k%0d", k), p_en, (k >= 7 && k <= 9));
      if (k == 7) begin
        chk("lat_busy", p_busy, 1);
        chk("lat_lvl_en", l_en, 1);
      end
      if (k == 12) begin
        chk("lat_d", p_d, 1);
        chk("lat_cnt", p_cnt, 1);
      end
      if (k == 40) chk("hold_busy", p_busy, 1);
      if (k == 30) raw_en = 1'b0;
      if (k == 31) raw_en = 1'b1;
      if (p_en) hi++;
    end
    chk("hold_hi_cycles", hi, 3);
    chk("hold_cnt", p_cnt, 1);
    chk("lvl_busy", l_busy, 0);
    raw_en = 1'b0;
    step(10);
    chk("rel_busy", p_busy, 0);

    // Second press with D toggled during the strobe: D frozen until IDLE.
    raw_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 7) begin
        chk("p2_en", p_en, 1);
        raw_d = 1'b0;
      end
    end
    chk("p2_cnt", p_cnt, 2);
    chk("dhold_wait", p_d, 1);
    chk("dhold_busy", p_busy, 1);
    chk("dhold_lvl_d", l_d, 0);
    raw_en = 1'b0;
    step(6);
    chk("dhold_k26", p_d, 1);
    step(1);
    chk("dhold_idle", p_d, 0);
    chk("dhold_idle_busy", p_busy, 0);
    step(5);

    // Glitch: 3 high cycles never reach the debounce threshold.
    raw_en = 1'b1;
    step(3);
    raw_en = 1'b0;
    hi = 0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      if (p_en) hi++;
    end
    chk("glitch_hi", hi, 0);
    chk("glitch_cnt", p_cnt, 2);

    // ena dropped mid-strobe, then restored while en is still held.
    raw_en = 1'b1;
    step(7);
    chk("ena_en_on", p_en, 1);
    chk("ena_cnt_on", p_cnt, 3);
    ena = 1'b0;
    step(1);
    chk("ena_en_off", p_en, 0);
    chk("ena_busy_off", p_busy, 0);
    chk("ena_cnt_off", p_cnt, 3);
    chk("ena_lvl_en", l_en, 0);
    step(4);
    ena = 1'b1;
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (p_en) hi++;
    end
    chk("ena_rearm_hi", hi, 0);
    chk("ena_rearm_cnt", p_cnt, 3);
    raw_en = 1'b0;
    step(12);

    // Level mode window: en_out high after edges 7..26.
    raw_en = 1'b1;
    hi = 0;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      if (k == 20) raw_en = 1'b0;
      if (l_en !== logic'(k >= 7 && k <= 26)) hi++;
      if (l_busy) hi++;
    end
    chk("lvl_window_errs", hi, 0);
    chk("lvl_cnt_idle", l_cnt, 0);
    chk("lvl_pls_cnt", p_cnt, 4);

    // Wrap: 251 more strobes reaches 255, one more wraps to 0.
    for (int i = 0; i < 251; i++) press(8);
    chk("wrap_255", p_cnt, 255);
    press(8);
    chk("wrap_0", p_cnt, 0);

    // Async reset mid-strobe drops en_out with no clock edge.
    raw_en = 1'b1;
    step(7);
    chk("arst_pre_en", p_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", p_en, 0);
    chk("arst_busy", p_busy, 0);
    chk("arst_cnt", p_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dlatch_input_conditioner.md
Name: dlatch_input_conditioner

Overview:
Front-end stage that feeds the D-latch block. It conditions two raw pad inputs (data, enable) through a synchronizer and a debouncer. It then drives the latch's D and EN: either as a level or as a fixed-width enable strobe, with D held stable for the whole strobe. A strobe counter and a busy flag are exported for the debug outputs.

Parameters:
SYNC_STAGES, 2, flip-flops in each synchronizer chain (legal >=2)
DEBOUNCE_CYCLES, 1000, consecutive mismatching cycles needed to accept a new input level (legal >=1)
EN_PULSE_CYCLES, 1, en_out high time in pulse mode, in clk cycles (legal >=1)
EN_MODE, 1, 0 = level mode (en_out follows debounced enable), 1 = pulse mode (strobe on rising edge)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
ena  input  1  block enable; low forces the strobe FSM idle
raw_d  input  1  unsynchronized data pad
raw_en  input  1  unsynchronized enable pad
d_out  output  1  conditioned data to latch D
en_out  output  1  conditioned enable to latch EN
busy  output  1  high while the FSM is not IDLE
strobe_cnt  output  8  count of strobes issued, wraps at 255->0

Behaviour:
- One clock domain (clk). rst_n is asynchronous and active-low. All registers clear to 0 on assertion, including sync chains, debounce counters, stable levels, FSM (IDLE), d_hold, d_out, en_out, busy and strobe_cnt. en_out drops immediately, without waiting for a clock edge.
- Synchronizer: each raw input passes through SYNC_STAGES flops. A raw level that is stable before edge 0 appears at the chain output after edge SYNC_STAGES.
- Debouncer, one per channel: holds a stable level and a counter of width clog2(DEBOUNCE_CYCLES)+1.
  - When sync == stable at an edge, the counter clears.
  - When sync != stable at an edge, the counter increments.
  - At the edge where the counter == DEBOUNCE_CYCLES-1 and sync != stable: stable <= sync and the counter clears.
  - A single matching cycle (glitch) restarts the count.
  - The stable level therefore changes at edge SYNC_STAGES+DEBOUNCE_CYCLES after a clean raw change.
- Level mode (EN_MODE=0): d_out and en_out are registered copies of the debounced levels, one edge after the stable change. If ena=0, en_out is 0. The FSM stays IDLE, busy=0, and strobe_cnt does not count.
- Pulse mode (EN_MODE=1), FSM with states IDLE, PULSE, WAIT_LOW:
  - IDLE: en_out=0, and d_out tracks debounced d (registered). On the rising edge of debounced en (prev 0, now 1) with ena=1: go to PULSE, capture d_hold <= debounced d, load the pulse counter, and increment strobe_cnt.
  - PULSE: en_out=1 and d_out=d_hold (frozen even if debounced d changes). After EN_PULSE_CYCLES cycles in PULSE: go to WAIT_LOW.
  - WAIT_LOW: en_out=0 and d_out=d_hold. Return to IDLE on the first edge where debounced en=0. Holding the button produces exactly one strobe.
- Latency: a clean raw_en rise at edge 0 gives en_out=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. In pulse mode it stays high for exactly EN_PULSE_CYCLES cycles.
- ena=0 at any time:
  - The FSM is forced to IDLE at the next edge and en_out=0 from that edge on.
  - A strobe cut short this way still counts.
  - The debouncers keep running.
  - Debounced en already high when ena returns does not strobe; a fresh rising edge is required.
- Simultaneous raw_d and raw_en change: both debounce in parallel, and d_hold captures the debounced d value at the strobe edge. If d settles at the same edge as en, d_hold takes the new d.
- strobe_cnt wraps 255 -> 0 with no flag.
- busy = (state != IDLE). It is registered with the state.

Test Plan:
- Reset/idle: rst_n low with raw pins toggling -> d_out=en_out=busy=0 and strobe_cnt=0. Asserting rst_n asynchronously mid-PULSE drops en_out with no clock edge.
- Latency (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EN_PULSE_CYCLES=3, EN_MODE=1): raw_d=1 held, raw_en 0->1 at edge 0 -> en_out=1 on edges 7..9, 0 after edge 10, d_out=1, and strobe_cnt=1.
- Glitch rejection: raw_en high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> en_out never rises and strobe_cnt stays 0. A 1-cycle low glitch inside a held-high input causes no second strobe.
- D hold: during PULSE, toggle raw_d (already debounced) -> d_out stays at the captured value until the FSM returns to IDLE, then follows the new d.
- Held button / re-arm: raw_en held high for 50 cycles -> exactly one strobe. Release, then press again -> second strobe and strobe_cnt=2. Issue 256 strobes -> strobe_cnt=0.
- ena and level mode: ena=0 during PULSE -> en_out=0 at the next edge and strobe_cnt is unchanged. With EN_MODE=0, raw_en high for 20 cycles -> en_out high from edge 7 until 7 cycles after raw_en falls, and busy=0 throughout.
